// File: rtl/tree_if.sv
// Request/result bundle for the binary-search-tree key store.
//   k0, k1, wr_en, rd_en : find / insert / insert / remove-minimum requests
//   sw                   : 4-bit key operand
//   led                  : registered result {flag, slot[2:0], key[3:0]}
//   tree_counter         : number of stored keys (0..7)
//   buf_empty, buf_full  : count==0 / count==7
// master drives requests, slave (the tree) drives results.
interface tree_if;
  logic       k0;
  logic       k1;
  logic       wr_en;
  logic       rd_en;
  logic [3:0] sw;
  logic [7:0] led;
  logic [2:0] tree_counter;
  logic       buf_empty;
  logic       buf_full;

  modport master (
    output k0, k1, wr_en, rd_en, sw,
    input  led, tree_counter, buf_empty, buf_full
  );

  modport slave (
    input  k0, k1, wr_en, rd_en, sw,
    output led, tree_counter, buf_empty, buf_full
  );
endinterface

// File: rtl/tree.sv
// Seven-slot binary search tree of unique 4-bit keys.
// One operation per clock, priority remove-min > insert > find; every
// operation completes in the edge that samples it (traversals are unrolled
// combinationally over at most 7 levels).
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : tree_if.slave request/result bundle
module tree (
  input  logic   clk,
  input  logic   rst,
  tree_if.slave  bus
);

  localparam logic [2:0] NULL_PTR = 3'd7;

  // Slot storage; key and child pointers are only meaningful while valid.
  logic [6:0] valid_r;
  logic [3:0] key_r [7];
  logic [2:0] lft_r [7];
  logic [2:0] rgt_r [7];
  logic [2:0] root_r;
  logic [2:0] cnt_r;
  logic [7:0] led_r;

  // Key search results.
  logic       found;
  logic [2:0] fslot;
  logic [2:0] par;
  logic       go_right;
  logic [2:0] cur;
  logic       sdone;

  // Minimum search results.
  logic [2:0] mnode;
  logic [2:0] mpar;
  logic       mdone;

  logic [2:0] free_slot;
  logic       ins_req;
  logic       full;
  logic       empty;

  assign ins_req = bus.k1 | bus.wr_en;
  assign full    = (cnt_r == 3'd7);
  assign empty   = (cnt_r == 3'd0);

  // Walk from the root toward sw; par/go_right record where a new node
  // would be linked if the walk falls off the tree.
  always_comb begin
    found    = 1'b0;
    fslot    = NULL_PTR;
    par      = NULL_PTR;
    go_right = 1'b0;
    cur      = root_r;
    sdone    = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!sdone) begin
        if (cur == NULL_PTR) begin
          sdone = 1'b1;
        end else if (key_r[cur] == bus.sw) begin
          found = 1'b1;
          fslot = cur;
          sdone = 1'b1;
        end else begin
          par      = cur;
          go_right = (bus.sw > key_r[cur]);
          cur      = go_right ? rgt_r[cur] : lft_r[cur];
        end
      end
    end
  end

  // Leftmost node from the root is the minimum; mpar is its parent.
  always_comb begin
    mnode = root_r;
    mpar  = NULL_PTR;
    mdone = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (!mdone) begin
        if (mnode != NULL_PTR && lft_r[mnode] != NULL_PTR) begin
          mpar  = mnode;
          mnode = lft_r[mnode];
        end else begin
          mdone = 1'b1;
        end
      end
    end
  end

  // Descending scan so the lowest free index wins.
  always_comb begin
    free_slot = NULL_PTR;
    for (int i = 6; i >= 0; i--) begin
      if (!valid_r[i]) free_slot = 3'(i);
    end
  end

  // Register stage: storage, count and result update on the sampling edge.
  // Keys and pointers carry no reset; valid bits and root gate their use.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= '0;
      root_r  <= NULL_PTR;
      cnt_r   <= 3'd0;
      led_r   <= 8'h00;
    end else if (bus.rd_en) begin
      if (empty) begin
        led_r <= {1'b0, NULL_PTR, 4'b0000};
      end else begin
        if (mnode == root_r) root_r <= rgt_r[mnode];
        else                 lft_r[mpar] <= rgt_r[mnode];
        valid_r[mnode] <= 1'b0;
        cnt_r          <= cnt_r - 3'd1;
        led_r          <= {1'b1, mnode, key_r[mnode]};
      end
    end else if (ins_req) begin
      if (full) begin
        led_r <= {1'b0, NULL_PTR, bus.sw};
      end else if (found) begin
        led_r <= {1'b0, fslot, bus.sw};
      end else begin
        valid_r[free_slot] <= 1'b1;
        key_r[free_slot]   <= bus.sw;
        lft_r[free_slot]   <= NULL_PTR;
        rgt_r[free_slot]   <= NULL_PTR;
        if (root_r == NULL_PTR) root_r <= free_slot;
        else if (go_right)      rgt_r[par] <= free_slot;
        else                    lft_r[par] <= free_slot;
        cnt_r <= cnt_r + 3'd1;
        led_r <= {1'b1, free_slot, bus.sw};
      end
    end else if (bus.k0) begin
      if (found) led_r <= {1'b1, fslot, bus.sw};
      else       led_r <= {1'b0, NULL_PTR, 4'b0000};
    end
  end

  assign bus.led          = led_r;
  assign bus.tree_counter = cnt_r;
  assign bus.buf_empty    = (cnt_r == 3'd0);
  assign bus.buf_full     = (cnt_r == 3'd7);

endmodule

// File: tb/tb_tree.sv
// Directed scoreboard bench for tree: each issued operation queues its
// hand-computed result; a monitor pops and compares one cycle later.
module tb_tree;
  logic clk = 1'b0;
  logic rst;

  tree_if bus ();

  tree dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] led;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   applied     = 0;
  int   miscompares = 0;
  logic issue       = 1'b0;
  logic issued_d    = 1'b0;

  always @(posedge clk) issued_d <= issue;

  // Monitor: compare registered outputs at the falling edge after an issue.
  initial begin
    forever begin
      @(negedge clk);
      if (issued_d) begin
        if (exp_q.size() == 0) begin
          applied++;
          miscompares++;
          $display("FAIL scoreboard_underflow: output with no expectation queued");
        end else begin
          exp_t e;
          logic exp_empty, exp_full;
          e = exp_q.pop_front();
          exp_empty = (e.cnt == 3'd0);
          exp_full  = (e.cnt == 3'd7);
          applied++;
          if (bus.led !== e.led || bus.tree_counter !== e.cnt ||
              bus.buf_empty !== exp_empty || bus.buf_full !== exp_full) begin
            miscompares++;
            $display("FAIL %s: got led=%h cnt=%0d empty=%b full=%b, expected led=%h cnt=%0d empty=%b full=%b",
                     e.name, bus.led, bus.tree_counter, bus.buf_empty, bus.buf_full,
                     e.led, e.cnt, exp_empty, exp_full);
          end
        end
      end
    end
  end

  task automatic apply(input string name, input logic r, input logic f,
                       input logic ins, input logic we, input logic rm,
                       input logic [3:0] key, input logic [7:0] eled,
                       input logic [2:0] ecnt);
    exp_t e;
    @(negedge clk);
    rst       = r;
    bus.k0    = f;
    bus.k1    = ins;
    bus.wr_en = we;
    bus.rd_en = rm;
    bus.sw    = key;
    e.name = name;
    e.led  = eled;
    e.cnt  = ecnt;
    exp_q.push_back(e);
    issue = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    bus.k0    = 1'b0;
    bus.k1    = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    issue     = 1'b0;
  endtask

  task automatic build_1_10_8();
    apply("ins1",  0, 0, 1, 0, 0, 4'd1,  8'h81, 3'd1);
    apply("ins10", 0, 0, 1, 0, 0, 4'd10, 8'h9A, 3'd2);
    apply("ins8",  0, 0, 1, 0, 0, 4'd8,  8'hA8, 3'd3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.k0 = 1'b0; bus.k1 = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus.sw = 4'd0;
    repeat (2) @(posedge clk);

    apply("reset", 1, 0, 0, 0, 0, 4'd0, 8'h00, 3'd0);
    build_1_10_8();
    apply("find3",  0, 1, 0, 0, 0, 4'd3,  8'h70, 3'd3);
    apply("find10", 0, 1, 0, 0, 0, 4'd10, 8'h9A, 3'd3);
    apply("find8",  0, 1, 0, 0, 0, 4'd8,  8'hA8, 3'd3);
    apply("dup10",  0, 0, 1, 0, 0, 4'd10, 8'h1A, 3'd3);
    apply("wr_ins2", 0, 0, 0, 1, 0, 4'd2,  8'hB2, 3'd4);
    apply("ins3",   0, 0, 1, 0, 0, 4'd3,  8'hC3, 3'd5);
    apply("ins4",   0, 0, 1, 0, 0, 4'd4,  8'hD4, 3'd6);
    apply("ins12",  0, 0, 1, 0, 0, 4'd12, 8'hEC, 3'd7);
    apply("ins5_full", 0, 0, 1, 0, 0, 4'd5, 8'h75, 3'd7);
    apply("idle_hold", 0, 0, 0, 0, 0, 4'd9, 8'h75, 3'd7);
    apply("find12", 0, 1, 0, 0, 0, 4'd12, 8'hEC, 3'd7);

    apply("reset2", 1, 0, 0, 0, 0, 4'd0, 8'h00, 3'd0);
    apply("rm_empty", 0, 0, 0, 0, 1, 4'd0, 8'h70, 3'd0);
    apply("find_empty", 0, 1, 0, 0, 0, 4'd1, 8'h70, 3'd0);
    build_1_10_8();
    apply("rm_min1", 0, 0, 0, 0, 1, 4'd0,  8'h81, 3'd2);
    apply("rm_min8", 0, 0, 0, 0, 1, 4'd0,  8'hA8, 3'd1);
    apply("find1_gone", 0, 1, 0, 0, 0, 4'd1, 8'h70, 3'd1);
    apply("ins5_reuse", 0, 0, 1, 0, 0, 4'd5, 8'h85, 3'd2);
    apply("find5",  0, 1, 0, 0, 0, 4'd5,  8'h85, 3'd2);
    apply("find10b", 0, 1, 0, 0, 0, 4'd10, 8'h9A, 3'd2);

    apply("reset3", 1, 0, 0, 0, 0, 4'd0, 8'h00, 3'd0);
    build_1_10_8();
    apply("all_req_rm", 0, 1, 1, 1, 1, 4'd7, 8'h81, 3'd2);
    apply("rst_with_ins", 1, 0, 1, 0, 0, 4'd3, 8'h00, 3'd0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      applied++;
      miscompares++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
